pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/mips_pkg.sv | 19 +
 rtl/pc_ras_stack.sv | 51 +++++
 rtl/pc_sequencer.sv | 89 ++++++++
 tb/tb_pc_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: jump opcodes, RAS sizing default and PC-sequencer
// target-source encoding.
package mips_pkg;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  localparam int RAS_DEPTH_DEF = 8;

  typedef enum logic [2:0] {
    SRC_HOLD,
    SRC_JUMP,
    SRC_RET,
    SRC_JR,
    SRC_BRANCH,
    SRC_SEQ
  } pc_src_e;

endpackage

// File: rtl/pc_ras_stack.sv
// Circular return-address stack: a full push overwrites the oldest entry,
// an empty pop only raises the sticky underflow flag.
module pc_ras_stack #(
  parameter int PC_W  = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [PC_W-1:0]            push_data,
  output logic [PC_W-1:0]            top,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PC_W-1:0] mem [DEPTH];
  logic [PW-1:0]   ptr;

  // ptr names the next free slot; the top of stack sits one below it.
  assign top = mem[ptr - PW'(1)];

  always_ff @(posedge clock) begin
    if (push) mem[ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (count == CW'(DEPTH)) overflow <= 1'b1;
      else                     count    <= count + CW'(1);
    end else if (pop) begin
      if (count == '0) begin
        underflow <= 1'b1;
      end else begin
        ptr   <= ptr - PW'(1);
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Word-addressed next-PC selection with jump/link/return/jr/branch priority
// and a return-address stack fed by link and drained by ret.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter int              RAS_DEPTH = RAS_DEPTH_DEF,
  parameter logic [PC_W-1:0] RESET_VEC = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       jump,
  input  logic                       link,
  input  logic                       ret,
  input  logic                       jr,
  input  logic                       branch,
  input  logic                       zero,
  input  logic [25:0]                address,
  input  logic [15:0]                immediate,
  input  logic [PC_W-1:0]            rs_value,
  output logic [PC_W-1:0]            pc,
  output logic [PC_W-1:0]            pc_plus1,
  output logic                       link_we,
  output logic [PC_W-1:0]            link_data,
  output logic                       redirect,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_overflow,
  output logic                       ras_underflow
);

  pc_src_e         src;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] ras_top;
  logic            ras_push;
  logic            ras_pop;

  assign pc_plus1  = pc + PC_W'(1);
  assign link_we   = link & ~stall & ~reset;
  assign link_data = pc_plus1;

  always_comb begin
    src = SRC_SEQ;
    if (stall)              src = SRC_HOLD;
    else if (jump | link)   src = SRC_JUMP;
    else if (ret)           src = SRC_RET;
    else if (jr)            src = SRC_JR;
    else if (branch & zero) src = SRC_BRANCH;
  end

  always_comb begin
    pc_next = pc_plus1;
    case (src)
      SRC_HOLD:   pc_next = pc;
      SRC_JUMP:   pc_next = {pc_plus1[PC_W-1:26], address};
      // An empty stack falls back to the register target.
      SRC_RET:    pc_next = (ras_count != '0) ? ras_top : rs_value;
      SRC_JR:     pc_next = rs_value;
      SRC_BRANCH: pc_next = pc_plus1 + {{(PC_W-16){immediate[15]}}, immediate};
      default:    pc_next = pc_plus1;
    endcase
  end

  assign ras_push = (src == SRC_JUMP) & link;
  assign ras_pop  = (src == SRC_RET);

  always_ff @(posedge clock) begin
    if (reset) begin
      pc       <= RESET_VEC;
      redirect <= 1'b0;
    end else begin
      pc       <= pc_next;
      redirect <= (src != SRC_HOLD) && (src != SRC_SEQ);
    end
  end

  pc_ras_stack #(.PC_W(PC_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus1),
    .top       (ras_top),
    .count     (ras_count),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench: default-depth sequencer plus a RAS_DEPTH=2 copy sharing
// the same stimulus for the wrap-around stack cases.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset, stall, jump, link, ret, jr, branch, zero;
  logic [25:0] address;
  logic [15:0] immediate;
  logic [31:0] rs_value;

  logic [31:0] pc, pc_plus1, link_data;
  logic        link_we, redirect, ovf, unf;
  logic [3:0]  ras_count;

  logic [31:0] pc2, pc_plus1_2, link_data2;
  logic        link_we2, redirect2, ovf2, unf2;
  logic [1:0]  ras_count2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  pc_sequencer dut (
    .clock(clock), .reset(reset), .stall(stall), .jump(jump), .link(link),
    .ret(ret), .jr(jr), .branch(branch), .zero(zero), .address(address),
    .immediate(immediate), .rs_value(rs_value), .pc(pc), .pc_plus1(pc_plus1),
    .link_we(link_we), .link_data(link_data), .redirect(redirect),
    .ras_count(ras_count), .ras_overflow(ovf), .ras_underflow(unf)
  );

  pc_sequencer #(.RAS_DEPTH(2)) dut2 (
    .clock(clock), .reset(reset), .stall(stall), .jump(jump), .link(link),
    .ret(ret), .jr(jr), .branch(branch), .zero(zero), .address(address),
    .immediate(immediate), .rs_value(rs_value), .pc(pc2), .pc_plus1(pc_plus1_2),
    .link_we(link_we2), .link_data(link_data2), .redirect(redirect2),
    .ras_count(ras_count2), .ras_overflow(ovf2), .ras_underflow(unf2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset = 0; stall = 0; jump = 0; link = 0; ret = 0; jr = 0;
    branch = 0; zero = 0; address = '0; immediate = '0; rs_value = '0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic do_jr(input logic [31:0] tgt);
    jr = 1; rs_value = tgt;
    step();
  endtask

  initial begin
    idle();
    #1;
    // Reset wins over stall and jump.
    reset = 1; stall = 1; jump = 1; address = 26'h123;
    step();
    check("rst_pc", pc, 32'h0);
    check("rst_redirect", redirect, 0);
    check("rst_count", ras_count, 0);
    check("rst_flags", {ovf, unf}, 0);

    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("seq_pc%0d", i), pc, i);
      check($sformatf("seq_redir%0d", i), redirect, 0);
    end

    // Taken branch backwards by 5 from pc=10.
    do_jr(32'd10);
    check("jr_pc", pc, 32'd10);
    check("jr_redirect", redirect, 1);
    branch = 1; zero = 1; immediate = 16'hFFFB;
    step();
    check("br_taken_pc", pc, 32'd6);
    check("br_taken_redir", redirect, 1);
    do_jr(32'd10);
    branch = 1; zero = 0; immediate = 16'hFFFB;
    step();
    check("br_nt_pc", pc, 32'd11);
    check("br_nt_redir", redirect, 0);
    check("pc_plus1", pc_plus1, 32'd12);

    // Link keeps the upper six bits of pc+1.
    do_jr(32'h0400_0005);
    link = 1; address = 26'h100;
    #1;
    check("link_we", link_we, 1);
    check("link_data", link_data, 32'h0400_0006);
    step();
    check("link_pc", pc, 32'h0400_0100);
    check("link_count", ras_count, 1);
    check("link_redir", redirect, 1);
    ret = 1;
    step();
    check("ret_pc", pc, 32'h0400_0006);
    check("ret_count", ras_count, 0);
    check("ret_redir", redirect, 1);

    // Stall holds everything even with jump/link pending.
    link = 1; address = 26'h200;
    step();
    check("link2_pc", pc, 32'h0400_0200);
    for (int i = 0; i < 2; i++) begin
      stall = 1; jump = 1; link = 1; address = 26'h300;
      #1;
      check("stall_link_we", link_we, 0);
      step();
      check("stall_pc", pc, 32'h0400_0200);
      check("stall_count", ras_count, 1);
      check("stall_redir", redirect, 0);
    end
    jump = 1; address = 26'h300;
    step();
    check("unstall_pc", pc, 32'h0400_0300);
    check("unstall_redir", redirect, 1);
    check("unstall_count", ras_count, 1);

    // Depth-2 overflow and underflow.
    reset = 1;
    step();
    check("rst2_count", ras_count2, 0);
    do_jr(32'd4);  link = 1; address = 26'h3000; step();
    do_jr(32'd20); link = 1; address = 26'h3000; step();
    check("ovf_not_yet", ovf2, 0);
    do_jr(32'd40); link = 1; address = 26'h3000; step();
    check("ovf_flag", ovf2, 1);
    check("ovf_count", ras_count2, 2);
    check("deep_count", ras_count, 3);
    check("deep_no_ovf", ovf, 0);
    ret = 1; step();
    check("ret1_pc", pc2, 32'd41);
    ret = 1; step();
    check("ret2_pc", pc2, 32'd21);
    check("ret2_count", ras_count2, 0);
    check("no_unf_yet", unf2, 0);
    ret = 1; rs_value = 32'd99; step();
    check("unf_pc", pc2, 32'd99);
    check("unf_flag", unf2, 1);
    check("unf_count", ras_count2, 0);

    // Wrap and priority.
    do_jr(32'hFFFF_FFFF);
    step();
    check("wrap_pc", pc, 32'h0);
    check("wrap_redir", redirect, 0);
    jump = 1; address = 26'h55; jr = 1; rs_value = 32'h77;
    branch = 1; zero = 1; immediate = 16'h3;
    step();
    check("prio_pc", pc, 32'h55);
    ret = 1; jr = 1; rs_value = 32'h77; branch = 1; zero = 1; immediate = 16'h3;
    step();
    check("ret_over_jr_pc", pc2, 32'h77);
    reset = 1; stall = 1;
    step();
    check("rst_stall_pc", pc, 32'h0);
    check("rst_stall_flags", {unf, unf2}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule
